// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
//   fetch_state_t    : fetch sequencer states
//   opcode_t         : RV32 major opcodes, shared with the control unit
//   RESET_PC_DEFAULT : first fetch address after reset
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FULL,
    DRAIN
  } fetch_state_t;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I_LOAD = 7'b0000011,
    OP_I_ALU  = 7'b0010011,
    OP_S      = 7'b0100011,
    OP_B      = 7'b1100011,
    OP_AUIPC  = 7'b0010111,
    OP_LUI    = 7'b0110111,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus (valid/ready).
//   req   : request valid (master -> slave)
//   addr  : request address, stable while req=1 and ready=0
//   ready : single-cycle response strobe, completes the outstanding request
//   rdata : instruction word, valid with ready
// Modports: master (fetch unit), slave (instruction memory).
interface fetch_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched instruction that arrived while the
// IF/ID register could not accept it.
//   clk, rst    : clock, asynchronous active-high reset
//   load        : capture load_instr/load_pc
//   unload      : entry consumed (moved to IF/ID)
//   flush       : discard the entry (highest priority)
//   valid/instr/pc : buffered entry
module fetch_skid_buf #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  unload,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] load_instr,
  input  logic [ADDR_WIDTH-1:0] load_pc,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues requests on the imem bus,
// holds the IF/ID register and applies redirects from the control unit.
//   clk, rst          : clock, asynchronous active-high reset
//   imem              : instruction-memory bus (fetch_if.master)
//   stall             : downstream cannot accept, IF/ID holds
//   redirect/jret     : PCSrc / JRetSrc, applied to the instruction in IF/ID
//   imm_op/alu_result : branch/JAL offset and JALR target
//   instr_valid/instr/instr_pc/instr_pc_plus4 : IF/ID register contents
//   opcode/funct3/funct7 : decode slices of instr
// Optional: define FETCH_PERF_CNT_EN to add fetch_count/flush_count outputs.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_if.master               imem,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic                  jret,
  input  logic [ADDR_WIDTH-1:0] imm_op,
  input  logic [ADDR_WIDTH-1:0] alu_result,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]           fetch_count,
  output logic [31:0]           flush_count,
`endif
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [ADDR_WIDTH-1:0] instr_pc_plus4,
  output logic [6:0]            opcode,
  output logic [2:0]            funct3,
  output logic                  funct7
);

  fetch_state_t state, state_next;

  logic [ADDR_WIDTH-1:0] pc, pc_next, addr_q, target;
  logic                  req_q, req_next;
  logic                  redir_take, ifid_free;
  logic                  ifid_load_mem, skid_load, skid_unload, valid_next, addr_upd;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_instr;
  logic [ADDR_WIDTH-1:0] skid_pc;

  assign imem.req  = req_q;
  assign imem.addr = addr_q;

  assign redir_take = redirect && instr_valid;
  assign ifid_free  = !instr_valid || !stall;
  assign target     = jret ? (alu_result & ~{{(ADDR_WIDTH-1){1'b0}}, 1'b1})
                           : (instr_pc + imm_op);

  assign instr_pc_plus4 = instr_pc + {{(ADDR_WIDTH-3){1'b0}}, 3'd4};
  assign opcode         = instr[6:0];
  assign funct3         = instr[14:12];
  assign funct7         = instr[30];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; redirect outranks stall and any same-cycle response.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  state_next = FETCH;
      FETCH: begin
        if (redir_take)                   state_next = imem.ready ? FETCH : DRAIN;
        else if (imem.ready && !ifid_free) state_next = FULL;
      end
      FULL:  if (redir_take || !stall) state_next = FETCH;
      DRAIN: if (imem.ready) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // Control outputs
  always_comb begin
    ifid_load_mem = (state == FETCH) && imem.ready && !redir_take && ifid_free;
    skid_load     = (state == FETCH) && imem.ready && !redir_take && !ifid_free;
    skid_unload   = (state == FULL) && skid_valid && !stall && !redir_take;
    req_next      = (state_next == FETCH) || (state_next == DRAIN);
    // In DRAIN the bus keeps showing the abandoned address while pc already
    // holds the redirect target.
    addr_upd      = (state_next != DRAIN);

    pc_next = pc;
    if (redir_take)                         pc_next = target;
    else if ((state == FETCH) && imem.ready) pc_next = pc + {{(ADDR_WIDTH-3){1'b0}}, 3'd4};

    valid_next = instr_valid;
    if (redir_take)                        valid_next = 1'b0;
    else if (ifid_load_mem || skid_unload) valid_next = 1'b1;
    else if (instr_valid && !stall)        valid_next = 1'b0;
  end

  // PC, bus request and IF/ID register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      addr_q      <= RESET_PC;
      req_q       <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      pc          <= pc_next;
      req_q       <= req_next;
      instr_valid <= valid_next;
      if (addr_upd) addr_q <= pc_next;
      if (ifid_load_mem) begin
        instr    <= imem.rdata;
        instr_pc <= addr_q;
      end else if (skid_unload) begin
        instr    <= skid_instr;
        instr_pc <= skid_pc;
      end
    end
  end

  fetch_skid_buf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .unload     (skid_unload),
    .flush      (redir_take),
    .load_instr (imem.rdata),
    .load_pc    (addr_q),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (ifid_load_mem || skid_load) fetch_count <= fetch_count + 32'd1;
      if (redir_take)                 flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic        jret = 1'b0;
  logic [31:0] imm_op = '0;
  logic [31:0] alu_result = '0;
  logic        instr_valid;
  logic [31:0] instr, instr_pc, instr_pc_plus4;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, flush_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int unsigned mem_lat = 0;
  int unsigned cnt = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];

  fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) imem ();

  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hBFC0_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem),
    .stall          (stall),
    .redirect       (redirect),
    .jret           (jret),
    .imm_op         (imm_op),
    .alu_result     (alu_result),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count    (fetch_count),
    .flush_count    (flush_count),
`endif
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1234_5613;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: responds mem_lat cycles after a request first appears.
  initial begin
    imem.ready = 1'b0;
    imem.rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !imem.req) begin
        imem.ready = 1'b0;
        cnt = 0;
      end else if (cnt >= mem_lat) begin
        imem.ready = 1'b1;
        imem.rdata = mem_word(imem.addr);
        cnt = 0;
      end else begin
        imem.ready = 1'b0;
        cnt++;
      end
    end
  end

  // Monitor: every bus handshake and every IF/ID consumption pops the scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && imem.req && imem.ready) begin
        if (exp_addr.size() == 0) begin
          check("unexpected_req", imem.addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_addr.pop_front();
          check("req_addr", imem.addr, e);
        end
      end
      if (!rst && instr_valid && !stall) begin
        if (exp_pc.size() == 0) begin
          check("unexpected_instr", instr_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_pc.pop_front();
          check("consumed_pc", instr_pc, e);
          check("consumed_instr", instr, mem_word(e));
        end
      end
    end
  end

  initial begin
    exp_addr = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C, 32'hBFC00010,
                 32'hBFC00014, 32'hBFC00008, 32'hBFC0000C, 32'h00001002, 32'h00001006,
                 32'h00001102};
    exp_pc   = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C, 32'hBFC00010,
                 32'hBFC00008, 32'h00001002, 32'h00001102};
    repeat (3) step();
    check("rst_req", {31'd0, imem.req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_addr", imem.addr, 32'hBFC00000);
    rst = 1'b0;

    step();                                   // IDLE -> FETCH
    check("first_req", {31'd0, imem.req}, 32'd1);
    check("first_addr", imem.addr, 32'hBFC00000);
    check("first_valid", {31'd0, instr_valid}, 32'd0);
    step();
    check("lat_valid", {31'd0, instr_valid}, 32'd1);
    check("lat_pc", instr_pc, 32'hBFC00000);
    check("pc_plus4", instr_pc_plus4, 32'hBFC00004);
    check("opcode", {25'd0, opcode}, 32'h13);
    check("funct3", {29'd0, funct3}, 32'd5);
    check("funct7", {31'd0, funct7}, 32'd0);
    step();
    step();
    check("pre_stall_pc", instr_pc, 32'hBFC00008);
    stall = 1'b1;
    step();                                   // response lands in skid
    check("stall_req", {31'd0, imem.req}, 32'd0);
    check("stall_pc", instr_pc, 32'hBFC00008);
    check("stall_valid", {31'd0, instr_valid}, 32'd1);
    step();
    step();
    check("stall_hold_pc", instr_pc, 32'hBFC00008);
    stall = 1'b0;
    step();                                   // skid -> IF/ID
    check("skid_pc", instr_pc, 32'hBFC0000C);
    check("resume_addr", imem.addr, 32'hBFC00010);
    step();
    check("branch_pc", instr_pc, 32'hBFC00010);
    redirect = 1'b1; jret = 1'b0; imm_op = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    check("branch_flush_valid", {31'd0, instr_valid}, 32'd0);
    check("branch_target", imem.addr, 32'hBFC00008);
    step();
    check("branch_refill_pc", instr_pc, 32'hBFC00008);
    redirect = 1'b1; jret = 1'b1; alu_result = 32'h0000_1003;
    step();
    redirect = 1'b0; jret = 1'b0;
    check("jalr_target", imem.addr, 32'h00001002);
    @(negedge clk);
    mem_lat = 2;
    step();
    check("jalr_refill_pc", instr_pc, 32'h00001002);
    redirect = 1'b1; imm_op = 32'h0000_0100;  // request to 1006 still waiting
    step();
    redirect = 1'b0;
    check("drain_valid", {31'd0, instr_valid}, 32'd0);
    check("drain_req", {31'd0, imem.req}, 32'd1);
    check("drain_addr", imem.addr, 32'h00001006);
    step();
    check("drain_addr_hold", imem.addr, 32'h00001006);
    step();
    check("drain_exit_addr", imem.addr, 32'h00001102);
    check("drain_dropped", {31'd0, instr_valid}, 32'd0);
    step();
    step();
    step();
    check("drain_refill_pc", instr_pc, 32'h00001102);
    redirect = 1'b1; jret = 1'b1; alu_result = 32'h0000_2000;
    step();
    redirect = 1'b0; jret = 1'b0;
    check("drain2_addr", imem.addr, 32'h00001106);
    check("drain2_valid", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, 32'd8);
    check("flush_count", flush_count, 32'd4);
`endif
    check("phase1_addr_left", exp_addr.size(), 32'd0);
    check("phase1_pc_left", exp_pc.size(), 32'd0);

    @(negedge clk);
    rst = 1'b1;                               // asynchronous, mid-DRAIN
    #1;
    check("mid_rst_req", {31'd0, imem.req}, 32'd0);
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("mid_rst_instr", instr, 32'd0);
    check("mid_rst_instr_pc", instr_pc, 32'd0);
    check("mid_rst_addr", imem.addr, 32'hBFC00000);
`ifdef FETCH_PERF_CNT_EN
    check("mid_rst_fetch_count", fetch_count, 32'd0);
`endif
    mem_lat = 0;
    exp_addr = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008};
    exp_pc   = '{32'hBFC00000, 32'hBFC00004};
    step();
    step();
    rst = 1'b0;
    step();
    check("restart_addr", imem.addr, 32'hBFC00000);
    step();
    check("restart_pc", instr_pc, 32'hBFC00000);
    step();
    step();
    check("restart_pc2", instr_pc, 32'hBFC00008);
    rst = 1'b1;
    step();
    check("phase2_addr_left", exp_addr.size(), 32'd0);
    check("phase2_pc_left", exp_pc.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
